valu_seq_8: RTL and testbench
=============================

// Module: valu_seq_8
// PURPOSE
//  Vector element sequencer sitting upstream and downstream of the 8-bit lane ALU (alu_8).
//  Accepts one vector op (ctl, two packed operand vectors, length) via valid/ready.
//  Drives the ALU one element per cycle, collects the results into a packed result vector,
//  and presents that vector to writeback via valid/ready. One op is in flight at a time.
// PARAMETERS
//  LANES  8  max elements per vector; element width fixed at 8 bits
//  VL_W   4  width of op_vl/res_vl; must be >= $clog2(LANES+1)
// PORTS
//  clk        in   1         clock, all state updates on rising edge
//  rst        in   1         asynchronous, active-high reset
//  op_valid   in   1         op request present
//  op_ready   out  1         sequencer can accept an op (high only in IDLE)
//  op_ctl     in   4         ALU opcode passed unchanged to alu_ctl (0 add .. 6 ror, others give 0)
//  op_vl      in   VL_W      element count; 0 allowed; values > LANES clamped to LANES
//  op_scalar  in   1         1: b operand for every element = op_vb[7:0]
//  op_va      in   8*LANES   operand A, element i at [8i+7:8i]
//  op_vb      in   8*LANES   operand B, same packing
//  alu_ctl    out  4         to alu_8 ctl
//  alu_a      out  8         to alu_8 a
//  alu_b      out  8         to alu_8 b
//  alu_out    in   8         from alu_8 out, combinational, sampled same cycle
//  res_valid  out  1         result vector valid
//  res_ready  in   1         writeback accepts result
//  res_data   out  8*LANES   result vector, same packing; lanes >= vl are 0
//  res_vl     out  VL_W      clamped element count of the result
//  busy       out  1         high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, idx=0, all latched operands 0, res_data=0, res_vl=0,
//    res_valid=0, busy=0, alu_ctl/alu_a/alu_b=0; op_ready=1 once rst deasserts.
//  - States: IDLE, RUN, DONE (registered, 2-bit).
//  - IDLE: op_ready=1. On op_valid&op_ready: latch ctl, va, vb, scalar, vl_c=min(op_vl,LANES);
//    clear res_data; idx=0. vl_c==0 -> DONE; else -> RUN.
//  - RUN: alu_ctl=ctl_q, alu_a=va_q[idx], alu_b=scalar_q ? vb_q[7:0] : vb_q[idx].
//    Each edge: res_data[idx] <= alu_out; if idx==vl_c-1 -> DONE, else idx<=idx+1.
//  - DONE: res_valid=1, res_data/res_vl stable. On res_ready -> IDLE (res_valid low next cycle).
//    res_data holds its value in IDLE until the next op is accepted.
//  - ALU drive outputs are 0 outside RUN. op_ready=0 in RUN and DONE; op_valid ignored there.
//  - Latency: accept edge -> res_valid high after vl_c+1 edges (vl_c=0: 1 edge).
//    Throughput: one op per vl_c+2 cycles with res_ready held high.
//  - Widths: no arithmetic on data here; ALU result taken as 8 bits, no carry/flags.
//  - op_ctl not decoded; invalid codes simply yield ALU result 0 per element.
//  - idx width $clog2(LANES); never exceeds vl_c-1.
//  - Reset mid-RUN/DONE aborts op: partial results discarded, no res_valid pulse.
// TESTING (LANES=8)
//  1. add vl=4, va={1,2,3,4}, vb={10,20,30,40} -> res lanes0-3 = {11,22,33,44}, lanes4-7=0,
//     res_vl=4, res_valid 5 edges after accept, alu_a steps 1,2,3,4 on consecutive cycles.
//  2. lsl, scalar=1, vl=8, va all 0x81, vb[7:0]=1 -> all 8 lanes 0x02; alu_b=1 every RUN cycle.
//  3. op_vl=0 -> DONE one edge after accept, res_data=0, res_vl=0; op_vl=12 -> clamped, res_vl=8.
//  4. sub vl=2, res_ready low 3 cycles in DONE -> res_valid and res_data held, op_ready=0,
//     second op_valid ignored; accepted only after handshake completes and IDLE reached.
//  5. rst asserted mid-RUN at idx=2 -> res_valid, busy, alu_* drop to 0 without clock edge;
//     after release op_ready=1 and a new add op completes correctly.
//  6. back-to-back xor ops, res_ready tied 1, vl=3 -> res_valid pulses every 5 cycles, correct data.

Source files
------------

// File: rtl/valu_seq_8.sv
// valu_seq_8 - vector element sequencer around an external 8-bit lane ALU (alu_8).
//
// Takes one vector op per valid/ready handshake, feeds the ALU one element per
// cycle, packs the per-element results, and offers the packed vector to
// writeback via valid/ready. Only one op is in flight at a time.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   op_valid / op_ready   op request handshake (ready only while idle)
//   op_ctl, op_vl         ALU opcode (passed through), element count (clamped to LANES)
//   op_scalar             1: every element uses op_vb[7:0] as its b operand
//   op_va, op_vb          packed operand vectors, element i at [8i+7:8i]
//   alu_ctl/alu_a/alu_b   drive to alu_8, zero outside RUN
//   alu_out               combinational ALU result, captured in the same cycle
//   res_valid / res_ready result handshake
//   res_data, res_vl      packed result vector (lanes >= vl are 0), clamped count
//   busy                  high while an op is in RUN or DONE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an op; result of the previous op still visible
// RUN   | one element per cycle through the ALU, idx = current element
// DONE  | result vector presented, waiting for res_ready
module valu_seq_8 #(
  parameter int LANES = 8,
  parameter int VL_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [3:0]           op_ctl,
  input  logic [VL_W-1:0]      op_vl,
  input  logic                 op_scalar,
  input  logic [8*LANES-1:0]   op_va,
  input  logic [8*LANES-1:0]   op_vb,
  output logic [3:0]           alu_ctl,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  input  logic [7:0]           alu_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [8*LANES-1:0]   res_data,
  output logic [VL_W-1:0]      res_vl,
  output logic                 busy
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]   idx;
  logic [3:0]         ctl_q;
  logic [8*LANES-1:0] va_q;
  logic [8*LANES-1:0] vb_q;
  logic               scalar_q;
  logic [VL_W-1:0]    vl_q;

  logic [VL_W-1:0]    vl_clamp;
  logic               last;
  logic               accept;

  assign vl_clamp = (op_vl > VL_W'(LANES)) ? VL_W'(LANES) : op_vl;
  // idx is only meaningful in RUN, where vl_q >= 1, so vl_q - 1 never wraps there.
  assign last     = (VL_W'(idx) == (vl_q - VL_W'(1)));
  assign accept   = (state == S_IDLE) && op_valid;
  assign res_vl   = vl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    alu_ctl   = 4'd0;
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = (vl_clamp == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        alu_ctl = ctl_q;
        alu_a   = va_q[idx*8 +: 8];
        alu_b   = scalar_q ? vb_q[7:0] : vb_q[idx*8 +: 8];
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      ctl_q    <= '0;
      va_q     <= '0;
      vb_q     <= '0;
      scalar_q <= 1'b0;
      vl_q     <= '0;
      res_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ctl_q    <= op_ctl;
            va_q     <= op_va;
            vb_q     <= op_vb;
            scalar_q <= op_scalar;
            vl_q     <= vl_clamp;
            // Clearing here is what guarantees lanes >= vl read back as 0.
            res_data <= '0;
            idx      <= '0;
          end
        end
        S_RUN: begin
          res_data[idx*8 +: 8] <= alu_out;
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_valu_seq_8.sv
module tb_valu_seq_8;
  localparam int LANES = 8;
  localparam int VL_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [3:0]        op_ctl = '0;
  logic [VL_W-1:0]   op_vl = '0;
  logic              op_scalar = 1'b0;
  logic [63:0]       op_va = '0;
  logic [63:0]       op_vb = '0;
  logic [3:0]        alu_ctl;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [7:0]        alu_out;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [63:0]       res_data;
  logic [VL_W-1:0]   res_vl;
  logic              busy;

  valu_seq_8 #(.LANES(LANES), .VL_W(VL_W)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_ctl(op_ctl), .op_vl(op_vl),
    .op_scalar(op_scalar), .op_va(op_va), .op_vb(op_vb),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_vl(res_vl), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for alu_8: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 lsl, 6 ror, else 0.
  function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] dbl;
    dbl = {a, a} >> b[2:0];
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[2:0];
      4'd6: return dbl[7:0];
      default: return 8'd0;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_ctl, alu_a, alu_b);

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] expect_vec(input logic [3:0] c, input int vl, input logic sc,
                                             input logic [63:0] va, input logic [63:0] vb);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < vl; i++)
      r[i*8 +: 8] = alu_f(c, va[i*8 +: 8], sc ? vb[7:0] : vb[i*8 +: 8]);
    return r;
  endfunction

  // Transaction-level model: an accepted op spends vl cycles feeding elements,
  // then holds its result until res_ready is seen.
  bit          m_run = 0, m_valid = 0;
  int          m_k = 0, m_vl = 0, m_lvl = 0;
  logic [3:0]  m_ctl = '0;
  logic        m_sc = 1'b0;
  logic [63:0] m_va = '0, m_vb = '0, m_exp = '0, m_last = '0;
  bit          rec = 0;
  int          vq[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_res_data", res_data, 0);
      m_run = 0; m_valid = 0; m_last = '0; m_lvl = 0;
    end else begin
      if (m_run) begin
        chk("run_op_ready", op_ready, 0);
        chk("run_busy", busy, 1);
        chk("run_res_valid", res_valid, 0);
        chk("run_alu_ctl", alu_ctl, m_ctl);
        chk("run_alu_a", alu_a, m_va[m_k*8 +: 8]);
        chk("run_alu_b", alu_b, m_sc ? m_vb[7:0] : m_vb[m_k*8 +: 8]);
      end else if (m_valid) begin
        chk("done_op_ready", op_ready, 0);
        chk("done_busy", busy, 1);
        chk("done_res_valid", res_valid, 1);
        chk("done_res_data", res_data, m_exp);
        chk("done_res_vl", res_vl, m_vl);
        chk("done_alu_a", alu_a, 0);
        if (rec) vq.push_back(cyc);
      end else begin
        chk("idle_op_ready", op_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_res_valid", res_valid, 0);
        chk("idle_res_data", res_data, m_last);
        chk("idle_res_vl", res_vl, m_lvl);
        chk("idle_alu_a", alu_a, 0);
        chk("idle_alu_b", alu_b, 0);
      end
      if (m_run) begin
        m_k++;
        if (m_k == m_vl) begin m_run = 0; m_valid = 1; end
      end else if (m_valid) begin
        if (res_ready) begin m_valid = 0; m_last = m_exp; m_lvl = m_vl; end
      end else if (op_valid) begin
        m_ctl = op_ctl; m_sc = op_scalar; m_va = op_va; m_vb = op_vb;
        m_vl = (int'(op_vl) > LANES) ? LANES : int'(op_vl);
        m_exp = expect_vec(m_ctl, m_vl, m_sc, m_va, m_vb);
        m_k = 0;
        if (m_vl == 0) m_valid = 1; else m_run = 1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_op(input logic [3:0] c, input int vl, input logic sc,
                         input logic [63:0] va, input logic [63:0] vb, input bit hold);
    int n;
    op_ctl = c; op_vl = vl[VL_W-1:0]; op_scalar = sc; op_va = va; op_vb = vb;
    op_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) op_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until res_valid; returns at a negedge.
  task automatic wait_res(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (res_valid) break;
      if (lat > 40) begin chk("res_timeout", 0, 1); break; end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  int lat;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: add vl=4
    send_op(4'd0, 4, 1'b0, 64'h0000_0000_0403_0201, 64'hEEEE_EEEE_281E_140A, 0);
    wait_res(lat);
    chk("t1_latency", lat, 5);
    chk("t1_res_data", res_data, 64'h0000_0000_2C21_160B);
    chk("t1_res_vl", res_vl, 4);
    handshake();

    // 2: lsl scalar vl=8
    send_op(4'd5, 8, 1'b1, 64'h8181_8181_8181_8181, 64'hFFEE_DDCC_BBAA_9901, 0);
    wait_res(lat);
    chk("t2_latency", lat, 9);
    chk("t2_res_data", res_data, 64'h0202_0202_0202_0202);
    handshake();

    // 3: vl=0 and vl clamped from 12
    send_op(4'd0, 0, 1'b0, 64'h1122_3344_5566_7788, 64'h0101_0101_0101_0101, 0);
    wait_res(lat);
    chk("t3_vl0_latency", lat, 1);
    chk("t3_vl0_res_data", res_data, 64'h0);
    chk("t3_vl0_res_vl", res_vl, 0);
    handshake();
    send_op(4'd0, 12, 1'b0, 64'h0706_0504_0302_0100, 64'h1010_1010_1010_1010, 0);
    wait_res(lat);
    chk("t3_clamp_latency", lat, 9);
    chk("t3_clamp_res_vl", res_vl, 8);
    chk("t3_clamp_res_data", res_data, 64'h1716_1514_1312_1110);
    handshake();

    // 4: sub vl=2 with res_ready stalled and a second op pending
    send_op(4'd1, 2, 1'b0, 64'h0000_0000_0000_0A50, 64'h0000_0000_0000_0B10, 0);
    wait_res(lat);
    chk("t4_latency", lat, 3);
    @(posedge clk); #1;
    op_ctl = 4'd4; op_vl = 4'd3; op_scalar = 1'b0;
    op_va = 64'hAAAA_AAAA_AAF0_0FFF; op_vb = 64'h0000_0000_000F_0F0F;
    op_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4_stall_op_ready", op_ready, 0);
      chk("t4_stall_res_valid", res_valid, 1);
      chk("t4_stall_res_data", res_data, 64'h0000_0000_0000_FF40);
    end
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    chk("t4_idle_op_ready", op_ready, 1);
    chk("t4_idle_res_valid", res_valid, 0);
    @(posedge clk); #1 op_valid = 1'b0;
    wait_res(lat);
    chk("t4_second_latency", lat, 4);
    chk("t4_second_res_data", res_data, 64'h0000_0000_00FF_00F0);
    handshake();

    // 5: reset mid-RUN at idx=2
    send_op(4'd0, 6, 1'b0, 64'h0000_0605_0403_0201, 64'h0000_0101_0101_0101, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_res_valid", res_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_alu_a", alu_a, 0);
    chk("t5_rst_alu_b", alu_b, 0);
    chk("t5_rst_res_data", res_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    chk("t5_post_op_ready", op_ready, 1);
    send_op(4'd0, 3, 1'b0, 64'h0000_0000_0007_0605, 64'h0000_0000_0001_0101, 0);
    wait_res(lat);
    chk("t5_new_latency", lat, 4);
    chk("t5_new_res_data", res_data, 64'h0000_0000_0008_0706);
    handshake();

    // 6: back-to-back xor, res_ready tied high
    res_ready = 1'b1;
    rec = 1;
    send_op(4'd4, 3, 1'b0, 64'h0000_0000_0033_2211, 64'h0000_0000_00FF_FFFF, 1);
    send_op(4'd4, 3, 1'b0, 64'h0000_0000_0003_0201, 64'h0000_0000_0030_2010, 1);
    send_op(4'd4, 3, 1'b0, 64'h0000_0000_00AA_55F0, 64'h0000_0000_00AA_AA0F, 0);
    wait_res(lat);
    chk("t6_last_res_data", res_data, 64'h0000_0000_0000_FFFF);
    repeat (3) @(posedge clk);
    #1 rec = 0;
    res_ready = 1'b0;
    chk("t6_pulse_count", vq.size(), 3);
    if (vq.size() >= 3) begin
      chk("t6_period_a", vq[1] - vq[0], 5);
      chk("t6_period_b", vq[2] - vq[1], 5);
    end
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
